mem_np: RTL and testbench
=========================

# mem_np

Parametrised multi-port scratch memory for the autoencoder datapath: one synchronous write port, N_RD independently enabled synchronous read ports, and a hardware clear sequencer that sweeps the array to a known value after reset or on command. Successor to the fixed two-read-port weight/activation RAM. Adds:

- configurable read-port count;
- per-port read-valid;
- asynchronous reset;
- run-time clear;
- optional write-to-read forwarding.

It sits between the layer controller and the MAC array.

## Interface
Parameters:
- ADDR_WIDTH, 4, address bits per port
- DATA_WIDTH, 16, word width (Q-format fixed point, opaque to this block)
- DEPTH, 16, number of words; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WIDTH
- N_RD, 2, number of read ports (1..8)
- INIT_VAL, 0, DATA_WIDTH-bit value written by the clear sweep

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- clear  in  1  one-cycle pulse; starts a clear sweep (sampled only in IDLE)
- busy  out  1  high while the clear sweep runs
- write_en  in  1  write strobe
- write_addr  in  ADDR_WIDTH  write address
- write_data  in  DATA_WIDTH  write data
- read_en  in  N_RD  per-port read strobe
- read_addr  in  N_RD*ADDR_WIDTH  packed addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  N_RD*DATA_WIDTH  packed registered read data, same packing
- read_valid  out  N_RD  per-port valid, one cycle after the matching read_en

## Operation
FSM states: CLEAR, IDLE.

- **rst asserted:** enter CLEAR, clear pointer = 0.
- **CLEAR:** each posedge writes INIT_VAL to mem[ptr] and increments ptr.
  - When the write to DEPTH-1 completes, move to IDLE.
  - write_en, read_en and clear are ignored; read_valid = 0.
- **IDLE:** clear = 1 moves to CLEAR with ptr = 0. Normal operation below is suppressed in that same cycle.

Writes (IDLE): if write_en and write_addr < DEPTH, mem[write_addr] ← write_data at posedge. Writes with addr ≥ DEPTH are dropped.

Reads (IDLE), per port i, independently:
- **read_en[i] = 1:** read_data_i ← mem[addr_i] and read_valid[i] ← 1.
- **Out-of-range address (≥ DEPTH):** returns 0, with valid still 1.
- **read_en[i] = 0:** read_valid[i] ← 0 and read_data_i holds its previous value.

Any number of ports may read the same address in the same cycle; no arbitration, no stalls.

Same-cycle write and read to the same address: see Configuration.

## Timing
- **Reset values:** read_data all 0, read_valid all 0, busy = 1, state CLEAR, ptr = 0. Array contents are undefined until the sweep completes.
- **Clear sweep duration:** DEPTH posedges after rst deasserts.
  - busy falls at the DEPTH-th posedge.
  - The first read accepted is at posedge DEPTH+1.
- **Command clear:** a clear pulse at posedge k sets busy = 1 after k. busy falls after posedge k+DEPTH.
- **Reset mid-sweep:** restarts at ptr = 0, outputs return to reset values immediately (asynchronous).
- **Read latency:** exactly 1 cycle. Address and enable sampled at posedge k; data and valid visible after posedge k. No combinational path from read_addr to read_data.
- **Write latency:** data written at posedge k is visible to a read sampled at posedge k+1 in all configurations.
- **Throughput:** one write plus N_RD reads every cycle.

## Configuration
Macro: MEM_NP_FWD_EN.

- **Defined:** a read on port i at posedge k with read_addr_i == write_addr, write_en = 1 and the address in range returns write_data (write-first). The bypass mux sits before the read register, so latency stays 1.
- **Undefined:** the same collision returns the array's pre-write contents (read-first). No bypass logic is generated.

## Structure
- **Shared package** `autoenc_pkg`:
  - state encoding constants ST_CLEAR / ST_IDLE;
  - the default DATA_WIDTH and ADDR_WIDTH constants used across the autoencoder;
  - packing helper functions for flat port buses.
- **Sub-module** `mem_np_rd_port`: one registered read port. It contains the address range check, the optional forward mux, and the data/valid registers. It is instantiated N_RD times in a generate loop.
- **Top level:** the array, write logic and clear FSM.

## Test plan
1. Reset, then idle -> busy = 1 for exactly 16 posedges (DEPTH = 16). After that, reads of addrs 0..15 on both ports all return 0x0000 with valid = 1, one cycle after read_en.
2. Write 0xBEEF to addr 3, then next cycle read addr 3 on port 0 and addr 5 on port 1 -> port 0 returns 0xBEEF, port 1 returns 0x0000, both valid.
3. write_en = 1, addr 7, data 0x1234, old value 0x0055, with a same-cycle read of addr 7 -> 0x1234 with MEM_NP_FWD_EN defined, 0x0055 without.
4. read_en toggled 1,0,1 on port 1 with addrs 2,9,4 (mem[2] = 0xAAAA, mem[4] = 0x4444) -> read_valid 1,0,1 and read_data 0xAAAA, 0xAAAA (held), 0x4444.
5. Fill the array, pulse clear, issue writes and reads during busy -> writes dropped, read_valid = 0 throughout the sweep, all words equal INIT_VAL afterward. Assert rst at sweep cycle 8 -> busy stays 1, and the sweep restarts for a full 16 cycles.
6. DEPTH = 12, ADDR_WIDTH = 4, N_RD = 3: write 0xFFFF to addr 13 and read addr 13 -> write dropped, read returns 0x0000 with valid = 1. All three ports reading addr 0 simultaneously return identical data.

Source files
------------

// File: rtl/autoenc_pkg.sv
// autoenc_pkg: definitions shared across the autoencoder datapath.
//   - AE_DATA_WIDTH / AE_ADDR_WIDTH : default word and address widths
//   - mem_state_e                   : clear-sequencer state encoding (ST_CLEAR, ST_IDLE)
//   - lane_lo()                     : low bit index of a lane inside a flat packed bus
package autoenc_pkg;

  localparam int AE_DATA_WIDTH = 16;
  localparam int AE_ADDR_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_e;

  // Lane `lane` of a flat bus made of `width`-bit lanes starts at this bit.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mem_np_rd_port.sv
// mem_np_rd_port: one registered read port of mem_np.
// Optional feature macro: MEM_NP_FWD_EN (write-first bypass of a same-cycle write).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   accept      : high when the memory is idle and normal accesses are allowed
//   read_en     : read strobe for this port
//   read_addr   : word address for this port
//   mem_flat    : whole array, word w at bits [w*DATA_WIDTH +: DATA_WIDTH]
//   fwd_we/fwd_addr/fwd_data : qualified write of this cycle (MEM_NP_FWD_EN only)
//   read_data   : registered read data, holds when no read is accepted
//   read_valid  : one-cycle valid for read_data
module mem_np_rd_port
  import autoenc_pkg::*;
#(
  parameter int ADDR_WIDTH = AE_ADDR_WIDTH,
  parameter int DATA_WIDTH = AE_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        accept,
  input  logic                        read_en,
  input  logic [ADDR_WIDTH-1:0]       read_addr,
  input  logic [DEPTH*DATA_WIDTH-1:0] mem_flat,
`ifdef MEM_NP_FWD_EN
  input  logic                        fwd_we,
  input  logic [ADDR_WIDTH-1:0]       fwd_addr,
  input  logic [DATA_WIDTH-1:0]       fwd_data,
`endif
  output logic [DATA_WIDTH-1:0]       read_data,
  output logic                        read_valid
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic                  in_range_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  assign in_range_s = ({1'b0, read_addr} < DEPTH_W);

  // Select the word to capture: bypassed write data, array word, or zero when out of range.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
`ifdef MEM_NP_FWD_EN
    // fwd_we is only set for in-range writes, so an address match implies in range.
    if (fwd_we && (fwd_addr == read_addr)) begin
      rd_word_s = fwd_data;
    end else if (in_range_s) begin
      rd_word_s = mem_flat[lane_lo(int'(read_addr), DATA_WIDTH) +: DATA_WIDTH];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
`else
    if (in_range_s) begin
      rd_word_s = mem_flat[lane_lo(int'(read_addr), DATA_WIDTH) +: DATA_WIDTH];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
`endif
  end

  // Output registers: data loads only on an accepted read, valid pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data  <= {DATA_WIDTH{1'b0}};
      read_valid <= 1'b0;
    end else if (accept && read_en) begin
      read_data  <= rd_word_s;
      read_valid <= 1'b1;
    end else begin
      read_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_np.sv
// mem_np: multi-port scratch memory with one write port, N_RD registered read
// ports and a clear sequencer that fills the array with INIT_VAL after reset or
// on a clear command.
// Optional feature macro: MEM_NP_FWD_EN (same-cycle write is forwarded to reads).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : one-cycle pulse, starts a clear sweep when idle
//   busy       : high while the clear sweep runs
//   write_en, write_addr, write_data : write port (out-of-range writes dropped)
//   read_en    : per-port read strobe
//   read_addr  : packed per-port addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   read_data  : packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_valid : per-port valid, one cycle after an accepted read_en
module mem_np
  import autoenc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = AE_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = AE_DATA_WIDTH,
  parameter int                    DEPTH      = 16,
  parameter int                    N_RD       = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = {DATA_WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  output logic                         busy,
  input  logic                         write_en,
  input  logic [ADDR_WIDTH-1:0]        write_addr,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic [N_RD-1:0]              read_en,
  input  logic [N_RD*ADDR_WIDTH-1:0]   read_addr,
  output logic [N_RD*DATA_WIDTH-1:0]   read_data,
  output logic [N_RD-1:0]              read_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);

  mem_state_e                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]       ptr_r, ptr_s;
  logic                        busy_r;
  logic                        accept_s;
  logic                        wr_in_range_s;
  logic                        mem_we_s;
  logic [ADDR_WIDTH-1:0]       mem_waddr_s;
  logic [DATA_WIDTH-1:0]       mem_wdata_s;
  logic [DEPTH*DATA_WIDTH-1:0] mem_r;

  // A clear pulse in IDLE suppresses normal accesses in that same cycle.
  assign accept_s      = (state_r == ST_IDLE) && !clear;
  assign wr_in_range_s = ({1'b0, write_addr} < DEPTH_W);
  assign busy          = busy_r;

`ifdef MEM_NP_FWD_EN
  logic fwd_we_s;
  assign fwd_we_s = accept_s && write_en && wr_in_range_s;
`endif

  // Clear sequencer state, sweep pointer and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_WIDTH{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      busy_r  <= (state_s == ST_CLEAR);
    end
  end

  // Next state: sweep one word per cycle, return to IDLE after the last word.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r == LAST_PTR) begin
          state_s = ST_IDLE;
          ptr_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s = ST_CLEAR;
          ptr_s   = ptr_r + PTR_ONE;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_s = ST_CLEAR;
          ptr_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s = ST_IDLE;
          ptr_s   = ptr_r;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        ptr_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Write port mux: the sweep owns the array while clearing, the user port otherwise.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_r;
    mem_wdata_s = INIT_VAL;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ptr_r;
      mem_wdata_s = INIT_VAL;
    end else if (accept_s && write_en && wr_in_range_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = write_addr;
      mem_wdata_s = write_data;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; no reset, contents are defined by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[lane_lo(int'(mem_waddr_s), DATA_WIDTH) +: DATA_WIDTH] <= mem_wdata_s;
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    mem_np_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .accept     (accept_s),
      .read_en    (read_en[i]),
      .read_addr  (read_addr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]),
      .mem_flat   (mem_r),
`ifdef MEM_NP_FWD_EN
      .fwd_we     (fwd_we_s),
      .fwd_addr   (write_addr),
      .fwd_data   (write_data),
`endif
      .read_data  (read_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .read_valid (read_valid[i])
    );
  end

endmodule

// File: tb/tb_mem_np.sv
// tb_mem_np: directed testbench for mem_np (default 16x16, 2 read ports) plus a
// second instance with DEPTH=12, N_RD=3 for the non-power-of-two boundary.
module tb_mem_np;

  int checks   = 0;
  int failures = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        clear = 1'b0;
  logic        busy;
  logic        write_en = 1'b0;
  logic [3:0]  write_addr = 4'h0;
  logic [15:0] write_data = 16'h0000;
  logic [1:0]  read_en = 2'b00;
  logic [7:0]  read_addr = 8'h00;
  logic [31:0] read_data;
  logic [1:0]  read_valid;

  logic        c_clear = 1'b0;
  logic        c_busy;
  logic        c_we = 1'b0;
  logic [3:0]  c_waddr = 4'h0;
  logic [15:0] c_wdata = 16'h0000;
  logic [2:0]  c_ren = 3'b000;
  logic [11:0] c_raddr = 12'h000;
  logic [47:0] c_rdata;
  logic [2:0]  c_rvalid;

  always #5 clk = ~clk;

  mem_np #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16), .N_RD(2), .INIT_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid)
  );

  mem_np #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12), .N_RD(3), .INIT_VAL(16'h0000)) dut12 (
    .clk(clk), .rst(rst), .clear(c_clear), .busy(c_busy),
    .write_en(c_we), .write_addr(c_waddr), .write_data(c_wdata),
    .read_en(c_ren), .read_addr(c_raddr), .read_data(c_rdata), .read_valid(c_rvalid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    write_en = 1'b1; write_addr = a; write_data = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++;
    if (read_valid !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b expected 00", read_valid); end
    checks++;
    if (read_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", read_data); end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL reset_sweep_len: got %0d expected 16", n); end
    for (int a = 0; a < 16; a++) begin
      read_en = 2'b11;
      read_addr = {4'(15 - a), 4'(a)};
      step();
      checks++;
      if (read_valid !== 2'b11 || read_data !== 32'h0) begin
        failures++;
        $display("FAIL post_reset_read a=%0d: got valid %b data %h expected 11 / 0", a, read_valid, read_data);
      end
    end
    read_en = 2'b00;
    step();
  endtask

  task automatic test_write_read();
    do_write(4'd3, 16'hBEEF);
    read_en = 2'b11; read_addr = {4'd5, 4'd3};
    step();
    read_en = 2'b00;
    checks++;
    if (read_data[15:0] !== 16'hBEEF || read_valid[0] !== 1'b1) begin
      failures++; $display("FAIL wr_rd_p0: got %h/%b expected beef/1", read_data[15:0], read_valid[0]);
    end
    checks++;
    if (read_data[31:16] !== 16'h0000 || read_valid[1] !== 1'b1) begin
      failures++; $display("FAIL wr_rd_p1: got %h/%b expected 0000/1", read_data[31:16], read_valid[1]);
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
`ifdef MEM_NP_FWD_EN
    exp = 16'h1234;
`else
    exp = 16'h0055;
`endif
    do_write(4'd7, 16'h0055);
    write_en = 1'b1; write_addr = 4'd7; write_data = 16'h1234;
    read_en = 2'b01; read_addr = {4'd0, 4'd7};
    step();
    write_en = 1'b0;
    checks++;
    if (read_data[15:0] !== exp || read_valid[0] !== 1'b1) begin
      failures++; $display("FAIL collision: got %h expected %h", read_data[15:0], exp);
    end
    step();
    read_en = 2'b00;
    checks++;
    if (read_data[15:0] !== 16'h1234) begin
      failures++; $display("FAIL after_collision: got %h expected 1234", read_data[15:0]);
    end
  endtask

  task automatic test_read_enable();
    do_write(4'd2, 16'hAAAA);
    do_write(4'd4, 16'h4444);
    read_en = 2'b10; read_addr = {4'd2, 4'd0};
    step();
    checks++;
    if (read_valid[1] !== 1'b1 || read_data[31:16] !== 16'hAAAA) begin
      failures++; $display("FAIL ren_1: got %b/%h expected 1/aaaa", read_valid[1], read_data[31:16]);
    end
    read_en = 2'b00; read_addr = {4'd9, 4'd0};
    step();
    checks++;
    if (read_valid[1] !== 1'b0 || read_data[31:16] !== 16'hAAAA) begin
      failures++; $display("FAIL ren_0_hold: got %b/%h expected 0/aaaa", read_valid[1], read_data[31:16]);
    end
    read_en = 2'b10; read_addr = {4'd4, 4'd0};
    step();
    read_en = 2'b00;
    checks++;
    if (read_valid[1] !== 1'b1 || read_data[31:16] !== 16'h4444) begin
      failures++; $display("FAIL ren_2: got %b/%h expected 1/4444", read_valid[1], read_data[31:16]);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int a = 0; a < 16; a++) do_write(4'(a), 16'h5A00 | 16'(a));
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy: got %b expected 1", busy); end
    write_en = 1'b1; write_addr = 4'd5; write_data = 16'hDEAD;
    read_en = 2'b11; read_addr = {4'd5, 4'd1};
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step(); n++;
      checks++;
      if (read_valid !== 2'b00) begin failures++; $display("FAIL clear_valid n=%0d: got %b expected 00", n, read_valid); end
    end
    write_en = 1'b0; read_en = 2'b00;
    checks++;
    if (n !== 16) begin failures++; $display("FAIL clear_len: got %0d expected 16", n); end
    for (int a = 0; a < 16; a++) begin
      read_en = 2'b01; read_addr = {4'd0, 4'(a)};
      step();
      checks++;
      if (read_data[15:0] !== 16'h0000 || read_valid[0] !== 1'b1) begin
        failures++; $display("FAIL clear_content a=%0d: got %h expected 0000", a, read_data[15:0]);
      end
    end
    read_en = 2'b00;
    // Reset in the middle of a command sweep.
    do_write(4'd1, 16'h7777);
    read_en = 2'b01; read_addr = {4'd0, 4'd1};
    step();
    read_en = 2'b00;
    checks++;
    if (read_data[15:0] !== 16'h7777) begin failures++; $display("FAIL pre_rst_read: got %h expected 7777", read_data[15:0]); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b1 || read_data !== 32'h0 || read_valid !== 2'b00) begin
      failures++; $display("FAIL mid_sweep_rst: got busy %b data %h valid %b expected 1/0/00", busy, read_data, read_valid);
    end
    step();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL restart_len: got %0d expected 16", n); end
    read_en = 2'b01; read_addr = {4'd0, 4'd1};
    step();
    read_en = 2'b00;
    checks++;
    if (read_data[15:0] !== 16'h0000) begin failures++; $display("FAIL restart_content: got %h expected 0000", read_data[15:0]); end
  endtask

  task automatic test_depth12();
    int n;
    n = 0;
    while (c_busy === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (c_busy !== 1'b0) begin failures++; $display("FAIL d12_idle: got busy %b expected 0", c_busy); end
    c_we = 1'b1; c_waddr = 4'd13; c_wdata = 16'hFFFF;
    step();
    c_we = 1'b0;
    c_ren = 3'b011; c_raddr = {4'd0, 4'd1, 4'd13};
    step();
    checks++;
    if (c_rdata[15:0] !== 16'h0000 || c_rvalid[0] !== 1'b1) begin
      failures++; $display("FAIL d12_oor_read: got %h/%b expected 0000/1", c_rdata[15:0], c_rvalid[0]);
    end
    checks++;
    if (c_rdata[31:16] !== 16'h0000) begin failures++; $display("FAIL d12_no_alias: got %h expected 0000", c_rdata[31:16]); end
    c_ren = 3'b000;
    c_we = 1'b1; c_waddr = 4'd0; c_wdata = 16'h3C3C;
    step();
    c_waddr = 4'd11; c_wdata = 16'h0B0B;
    step();
    c_we = 1'b0;
    c_ren = 3'b111; c_raddr = {4'd0, 4'd0, 4'd0};
    step();
    checks++;
    if (c_rdata !== {3{16'h3C3C}} || c_rvalid !== 3'b111) begin
      failures++; $display("FAIL d12_same_addr: got %h/%b expected 3c3c x3/111", c_rdata, c_rvalid);
    end
    c_ren = 3'b100; c_raddr = {4'd11, 4'd0, 4'd0};
    step();
    c_ren = 3'b000;
    checks++;
    if (c_rdata[47:32] !== 16'h0B0B || c_rvalid !== 3'b100) begin
      failures++; $display("FAIL d12_last_word: got %h/%b expected 0b0b/100", c_rdata[47:32], c_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_read_enable();
    test_clear();
    test_depth12();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
